// File: rtl/pe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared definitions for the PE stream controller: field and counter widths,
// the controller state encoding, and the per-layer word-count calculation.
// ---------------------------------------------------------------------------
package pe_ctrl_pkg;

    localparam int S_WIDTH    = 6;
    localparam int F_WIDTH    = 6;
    localparam int U_WIDTH    = 3;
    localparam int N_WIDTH    = 3;
    localparam int P_WIDTH    = 5;
    localparam int Q_WIDTH    = 3;
    localparam int ADDR_WIDTH = 16;
    localparam int CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CFG    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] w;
        logic [CNT_WIDTH-1:0] n_if;
        logic [CNT_WIDTH-1:0] n_flt;
        logic [CNT_WIDTH-1:0] n_ps;
    } word_counts_t;

    // Word totals for one layer pass. Filter and psum words pack four
    // values each, hence the divide by four on those totals.
    function automatic word_counts_t calc_counts(
        input logic [S_WIDTH-1:0] s,
        input logic [F_WIDTH-1:0] f,
        input logic [U_WIDTH-1:0] u,
        input logic [N_WIDTH-1:0] n,
        input logic [P_WIDTH-1:0] p,
        input logic [Q_WIDTH-1:0] q
    );
        word_counts_t         c;
        logic [CNT_WIDTH-1:0] s_c;
        logic [CNT_WIDTH-1:0] f_c;
        logic [CNT_WIDTH-1:0] u_c;
        logic [CNT_WIDTH-1:0] n_c;
        logic [CNT_WIDTH-1:0] p_c;
        logic [CNT_WIDTH-1:0] q_c;
        s_c     = CNT_WIDTH'(s);
        f_c     = CNT_WIDTH'(f);
        u_c     = CNT_WIDTH'(u);
        n_c     = CNT_WIDTH'(n);
        p_c     = CNT_WIDTH'(p);
        q_c     = CNT_WIDTH'(q);
        c.w     = (f_c - 16'd1) * u_c + s_c;
        c.n_if  = n_c * c.w * q_c;
        c.n_flt = (p_c * q_c * s_c) >> 2'd2;
        c.n_ps  = (p_c * n_c * f_c) >> 2'd2;
        return c;
    endfunction

endpackage

// File: rtl/pe_stream_reader.sv
// ---------------------------------------------------------------------------
// pe_stream_reader
// Fetches `total` words from a synchronous-read buffer (addresses 0..total-1)
// and pushes each into a PE input FIFO the cycle after the read.
// Ports: clk, reset (async active-low), go (stream enable; low clears state),
//        total, fifo_full, rd_data in; rd_en, rd_addr, push, data, complete out.
// ---------------------------------------------------------------------------
module pe_stream_reader
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [CNT_WIDTH-1:0]  total,
    input  logic                  fifo_full,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  complete
);

    logic [CNT_WIDTH-1:0] count_r;
    logic                 push_r;
    logic                 issue_s;

    // A read may issue only when the previous one has returned (push_r low),
    // which limits each stream to one word every two cycles.
    always_comb begin
        issue_s = 1'b0;
        if (go && !push_r && (count_r < total) && !fifo_full) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Word counter and return flag; both clear whenever the stream is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_WIDTH{1'b0}};
            push_r  <= 1'b0;
        end else if (!go) begin
            count_r <= {CNT_WIDTH{1'b0}};
            push_r  <= 1'b0;
        end else begin
            push_r <= issue_s;
            if (push_r) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Read data passes straight through in the return cycle; zero otherwise.
    always_comb begin
        data = {DATA_WIDTH{1'b0}};
        if (push_r) begin
            data = rd_data;
        end else begin
            data = {DATA_WIDTH{1'b0}};
        end
    end

    assign rd_en    = issue_s;
    assign rd_addr  = count_r;
    assign push     = push_r;
    assign complete = (count_r == total);

endmodule

// File: rtl/pe_stream_ctrl.sv
// ---------------------------------------------------------------------------
// pe_stream_ctrl
// Configures one PE wrapper and streams its operands for a layer pass:
// IDLE -> CFG (configure pulse) -> STREAM (three readers + opsum drainer)
// -> DONE (one-cycle done) -> IDLE.
// Ports: clk, reset (async active-low), start + layer config S/F/U/n/p/q in;
//        busy, done, pe_enable, pe_configure, pe_S..pe_q out; PE input
//        streams (push/data out, fifo_full in); opsum pop interface; three
//        buffer read ports; one opsum buffer write port.
// ---------------------------------------------------------------------------
module pe_stream_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH_IFMAP  = 16,
    parameter int DATA_WIDTH_FILTER = 64,
    parameter int DATA_WIDTH_PSUM   = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [S_WIDTH-1:0]           S,
    input  logic [F_WIDTH-1:0]           F,
    input  logic [U_WIDTH-1:0]           U,
    input  logic [N_WIDTH-1:0]           n,
    input  logic [P_WIDTH-1:0]           p,
    input  logic [Q_WIDTH-1:0]           q,
    output logic                         busy,
    output logic                         done,
    output logic                         pe_enable,
    output logic                         pe_configure,
    output logic [S_WIDTH-1:0]           pe_S,
    output logic [F_WIDTH-1:0]           pe_F,
    output logic [U_WIDTH-1:0]           pe_U,
    output logic [N_WIDTH-1:0]           pe_n,
    output logic [P_WIDTH-1:0]           pe_p,
    output logic [Q_WIDTH-1:0]           pe_q,
    input  logic                         pe_busy,
    output logic                         push_ifmap,
    output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
    input  logic                         ifmap_fifo_full,
    output logic                         push_filter,
    output logic [DATA_WIDTH_FILTER-1:0] filter,
    input  logic                         filter_fifo_full,
    output logic                         push_ipsum,
    output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
    input  logic                         ipsum_fifo_full,
    output logic                         pop_opsum,
    input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
    input  logic                         opsum_fifo_empty,
    output logic                         ifmap_rd_en,
    output logic [ADDR_WIDTH-1:0]        ifmap_rd_addr,
    input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap_rd_data,
    output logic                         filter_rd_en,
    output logic [ADDR_WIDTH-1:0]        filter_rd_addr,
    input  logic [DATA_WIDTH_FILTER-1:0] filter_rd_data,
    output logic                         ipsum_rd_en,
    output logic [ADDR_WIDTH-1:0]        ipsum_rd_addr,
    input  logic [DATA_WIDTH_PSUM-1:0]   ipsum_rd_data,
    output logic                         opsum_wr_en,
    output logic [ADDR_WIDTH-1:0]        opsum_wr_addr,
    output logic [DATA_WIDTH_PSUM-1:0]   opsum_wr_data
);

    ctrl_state_t          state_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 cfg_pulse_r;
    logic [S_WIDTH-1:0]   pe_s_r;
    logic [F_WIDTH-1:0]   pe_f_r;
    logic [U_WIDTH-1:0]   pe_u_r;
    logic [N_WIDTH-1:0]   pe_n_r;
    logic [P_WIDTH-1:0]   pe_p_r;
    logic [Q_WIDTH-1:0]   pe_q_r;
    logic [CNT_WIDTH-1:0] n_if_r;
    logic [CNT_WIDTH-1:0] n_flt_r;
    logic [CNT_WIDTH-1:0] n_ps_r;
    logic [CNT_WIDTH-1:0] opsum_cnt_r;
    logic                 gap_r;
    word_counts_t         counts_s;
    logic                 streaming_s;
    logic                 pop_s;
    logic                 if_complete_s;
    logic                 flt_complete_s;
    logic                 ps_complete_s;
    logic                 pass_complete_s;

    // Word totals derived from the live config inputs; latched only on start.
    always_comb begin
        counts_s = calc_counts(S, F, U, n, p, q);
    end

    assign streaming_s     = (state_r == ST_STREAM);
    assign pass_complete_s = if_complete_s && flt_complete_s && ps_complete_s &&
                             (opsum_cnt_r == n_ps_r) && !pe_busy;

    // Controller FSM with registered status, configure pulse and config fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_pulse_r <= 1'b0;
            pe_s_r      <= {S_WIDTH{1'b0}};
            pe_f_r      <= {F_WIDTH{1'b0}};
            pe_u_r      <= {U_WIDTH{1'b0}};
            pe_n_r      <= {N_WIDTH{1'b0}};
            pe_p_r      <= {P_WIDTH{1'b0}};
            pe_q_r      <= {Q_WIDTH{1'b0}};
            n_if_r      <= {CNT_WIDTH{1'b0}};
            n_flt_r     <= {CNT_WIDTH{1'b0}};
            n_ps_r      <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= ST_CFG;
                        busy_r      <= 1'b1;
                        cfg_pulse_r <= 1'b1;
                        pe_s_r      <= S;
                        pe_f_r      <= F;
                        pe_u_r      <= U;
                        pe_n_r      <= n;
                        pe_p_r      <= p;
                        pe_q_r      <= q;
                        n_if_r      <= counts_s.n_if;
                        n_flt_r     <= counts_s.n_flt;
                        n_ps_r      <= counts_s.n_ps;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CFG: begin
                    // Config fields are only meaningful during the pulse.
                    cfg_pulse_r <= 1'b0;
                    pe_s_r      <= {S_WIDTH{1'b0}};
                    pe_f_r      <= {F_WIDTH{1'b0}};
                    pe_u_r      <= {U_WIDTH{1'b0}};
                    pe_n_r      <= {N_WIDTH{1'b0}};
                    pe_p_r      <= {P_WIDTH{1'b0}};
                    pe_q_r      <= {Q_WIDTH{1'b0}};
                    state_r     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (pass_complete_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    cfg_pulse_r <= 1'b0;
                end
            endcase
        end
    end

    // Pop when a word is available and wanted; gap_r forces an idle cycle
    // after every pop so the FIFO's empty flag has time to update.
    always_comb begin
        pop_s = 1'b0;
        if (streaming_s && !opsum_fifo_empty && (opsum_cnt_r < n_ps_r) && !gap_r) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Opsum drain counter and gap flag; cleared outside the stream phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opsum_cnt_r <= {CNT_WIDTH{1'b0}};
            gap_r       <= 1'b0;
        end else if (!streaming_s) begin
            opsum_cnt_r <= {CNT_WIDTH{1'b0}};
            gap_r       <= 1'b0;
        end else begin
            gap_r <= pop_s;
            if (pop_s) begin
                opsum_cnt_r <= opsum_cnt_r + 16'd1;
            end else begin
                opsum_cnt_r <= opsum_cnt_r;
            end
        end
    end

    // Popped word goes straight to the output buffer in the pop cycle.
    always_comb begin
        opsum_wr_data = {DATA_WIDTH_PSUM{1'b0}};
        if (pop_s) begin
            opsum_wr_data = opsum;
        end else begin
            opsum_wr_data = {DATA_WIDTH_PSUM{1'b0}};
        end
    end

    assign pop_opsum     = pop_s;
    assign opsum_wr_en   = pop_s;
    assign opsum_wr_addr = opsum_cnt_r;
    assign busy          = busy_r;
    assign pe_enable     = busy_r;
    assign done          = done_r;
    assign pe_configure  = cfg_pulse_r;
    assign pe_S          = pe_s_r;
    assign pe_F          = pe_f_r;
    assign pe_U          = pe_u_r;
    assign pe_n          = pe_n_r;
    assign pe_p          = pe_p_r;
    assign pe_q          = pe_q_r;

    pe_stream_reader #(.DATA_WIDTH(DATA_WIDTH_IFMAP)) u_ifmap_rd (
        .clk       (clk),
        .reset     (reset),
        .go        (streaming_s),
        .total     (n_if_r),
        .fifo_full (ifmap_fifo_full),
        .rd_data   (ifmap_rd_data),
        .rd_en     (ifmap_rd_en),
        .rd_addr   (ifmap_rd_addr),
        .push      (push_ifmap),
        .data      (ifmap),
        .complete  (if_complete_s)
    );

    pe_stream_reader #(.DATA_WIDTH(DATA_WIDTH_FILTER)) u_filter_rd (
        .clk       (clk),
        .reset     (reset),
        .go        (streaming_s),
        .total     (n_flt_r),
        .fifo_full (filter_fifo_full),
        .rd_data   (filter_rd_data),
        .rd_en     (filter_rd_en),
        .rd_addr   (filter_rd_addr),
        .push      (push_filter),
        .data      (filter),
        .complete  (flt_complete_s)
    );

    pe_stream_reader #(.DATA_WIDTH(DATA_WIDTH_PSUM)) u_ipsum_rd (
        .clk       (clk),
        .reset     (reset),
        .go        (streaming_s),
        .total     (n_ps_r),
        .fifo_full (ipsum_fifo_full),
        .rd_data   (ipsum_rd_data),
        .rd_en     (ipsum_rd_en),
        .rd_addr   (ipsum_rd_addr),
        .push      (push_ipsum),
        .data      (ipsum),
        .complete  (ps_complete_s)
    );

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_stream_ctrl
// Self-checking bench for pe_stream_ctrl. Buffers and the opsum FIFO are
// modelled with arrays and a queue; expected word counts come from the layer
// formulas, expected stream contents from the buffer arrays in address order.
// ---------------------------------------------------------------------------
module tb_pe_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  S;
    logic [5:0]  F;
    logic [2:0]  U;
    logic [2:0]  n;
    logic [4:0]  p;
    logic [2:0]  q;
    logic        busy, done, pe_enable, pe_configure;
    logic [5:0]  pe_S, pe_F;
    logic [2:0]  pe_U, pe_n, pe_q;
    logic [4:0]  pe_p;
    logic        pe_busy;
    logic        push_ifmap, push_filter, push_ipsum;
    logic [15:0] ifmap;
    logic [63:0] filter, ipsum;
    logic        ifmap_fifo_full, filter_fifo_full, ipsum_fifo_full;
    logic        pop_opsum;
    logic [63:0] opsum;
    logic        opsum_fifo_empty;
    logic        ifmap_rd_en, filter_rd_en, ipsum_rd_en;
    logic [15:0] ifmap_rd_addr, filter_rd_addr, ipsum_rd_addr;
    logic [15:0] ifmap_rd_data;
    logic [63:0] filter_rd_data, ipsum_rd_data;
    logic        opsum_wr_en;
    logic [15:0] opsum_wr_addr;
    logic [63:0] opsum_wr_data;

    always #5 clk = ~clk;

    pe_stream_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .S(S), .F(F), .U(U), .n(n), .p(p), .q(q),
        .busy(busy), .done(done), .pe_enable(pe_enable), .pe_configure(pe_configure),
        .pe_S(pe_S), .pe_F(pe_F), .pe_U(pe_U), .pe_n(pe_n), .pe_p(pe_p), .pe_q(pe_q),
        .pe_busy(pe_busy),
        .push_ifmap(push_ifmap), .ifmap(ifmap), .ifmap_fifo_full(ifmap_fifo_full),
        .push_filter(push_filter), .filter(filter), .filter_fifo_full(filter_fifo_full),
        .push_ipsum(push_ipsum), .ipsum(ipsum), .ipsum_fifo_full(ipsum_fifo_full),
        .pop_opsum(pop_opsum), .opsum(opsum), .opsum_fifo_empty(opsum_fifo_empty),
        .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_addr(ifmap_rd_addr), .ifmap_rd_data(ifmap_rd_data),
        .filter_rd_en(filter_rd_en), .filter_rd_addr(filter_rd_addr), .filter_rd_data(filter_rd_data),
        .ipsum_rd_en(ipsum_rd_en), .ipsum_rd_addr(ipsum_rd_addr), .ipsum_rd_data(ipsum_rd_data),
        .opsum_wr_en(opsum_wr_en), .opsum_wr_addr(opsum_wr_addr), .opsum_wr_data(opsum_wr_data)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // buffer contents
    logic [15:0] if_mem  [0:511];
    logic [63:0] flt_mem [0:511];
    logic [63:0] ps_mem  [0:511];

    // per-pass model state
    int          cyc;
    int          n_exp [3];
    int          n_ps_e;
    int          rd_n [3];
    int          push_n [3];
    bit          last_rd [3];
    int          first_rd [3];
    int          first_push [3];
    int          wr_n, last_wr_cyc, done_n, done_cyc, cfg_n, busy_first;
    bit          last_pop, prev_pe_busy;
    logic [63:0] opq [$];
    int          produced;
    logic [5:0]  c_s, c_f;
    logic [2:0]  c_u, c_n, c_q;
    logic [4:0]  c_p;
    int          full_lo, full_hi, busy_until, produce_pct, restart_at;

    function automatic logic [63:0] mem_word(input int s, input int idx);
        case (s)
            0:       return {48'd0, if_mem[idx & 511]};
            1:       return flt_mem[idx & 511];
            default: return ps_mem[idx & 511];
        endcase
    endfunction

    function automatic logic any_out();
        return |{busy, done, pe_enable, pe_configure, pe_S, pe_F, pe_U, pe_n, pe_p, pe_q,
                 push_ifmap, ifmap, push_filter, filter, push_ipsum, ipsum, pop_opsum,
                 ifmap_rd_en, ifmap_rd_addr, filter_rd_en, filter_rd_addr,
                 ipsum_rd_en, ipsum_rd_addr, opsum_wr_en, opsum_wr_addr, opsum_wr_data};
    endfunction

    // Observe one cycle at the falling edge and compare against the model.
    task automatic sample();
        logic        rd_v [3];
        logic [15:0] addr_v [3];
        logic        push_v [3];
        logic [63:0] data_v [3];
        logic        full_v [3];
        @(negedge clk);
        rd_v   = '{ifmap_rd_en, filter_rd_en, ipsum_rd_en};
        addr_v = '{ifmap_rd_addr, filter_rd_addr, ipsum_rd_addr};
        push_v = '{push_ifmap, push_filter, push_ipsum};
        data_v = '{{48'd0, ifmap}, filter, ipsum};
        full_v = '{ifmap_fifo_full, filter_fifo_full, ipsum_fifo_full};
        for (int s = 0; s < 3; s++) begin
            if (rd_v[s]) begin
                check_val("rd_addr", addr_v[s], rd_n[s]);
                check_val("rd_when_full", full_v[s], 0);
                check_val("rd_rate", {last_rd[s], push_v[s]}, 0);
                check_val("rd_overrun", rd_n[s] < n_exp[s], 1);
                if (rd_n[s] == 0) first_rd[s] = cyc;
                rd_n[s]++;
            end
            if (push_v[s] || last_rd[s]) begin
                check_val("push_seq", push_v[s], last_rd[s]);
                if (push_v[s]) begin
                    check_val("push_data", data_v[s], mem_word(s, push_n[s]));
                    if (push_n[s] == 0) first_push[s] = cyc;
                    push_n[s]++;
                end
            end
            last_rd[s] = rd_v[s];
        end
        if (pop_opsum || opsum_wr_en) check_val("wr_en_eq_pop", opsum_wr_en, pop_opsum);
        if (pop_opsum) begin
            check_val("pop_when_empty", opq.size() == 0, 0);
            check_val("pop_gap", last_pop, 0);
            check_val("wr_addr", opsum_wr_addr, wr_n);
            check_val("pop_overrun", wr_n < n_ps_e, 1);
            if (opq.size() > 0) begin
                check_val("wr_data", opsum_wr_data, opq[0]);
                void'(opq.pop_front());
            end
            wr_n++;
            last_wr_cyc = cyc;
        end
        last_pop = pop_opsum;
        if (pe_configure) begin
            cfg_n++;
            check_val("cfg_time", cyc, 1);
            check_val("cfg_vals", {pe_S, pe_F, pe_U, pe_n, pe_p, pe_q},
                      {c_s, c_f, c_u, c_n, c_p, c_q});
        end else if (busy) begin
            check_val("cfg_clear", {pe_S, pe_F, pe_U, pe_n, pe_p, pe_q}, 0);
        end
        if (busy || pe_enable) check_val("pe_enable", pe_enable, busy);
        if (busy && busy_first < 0) busy_first = cyc;
        if (done) begin
            done_n++;
            done_cyc = cyc;
            check_val("done_after_wr", cyc > last_wr_cyc, 1);
            check_val("done_pe_busy", prev_pe_busy, 0);
        end
        prev_pe_busy = pe_busy;
    endtask

    // Drive the environment just after the rising edge.
    task automatic drive();
        @(posedge clk);
        #1;
        cyc++;
        ifmap_rd_data  = last_rd[0] ? if_mem[(rd_n[0] - 1) & 511]  : 16'($urandom);
        filter_rd_data = last_rd[1] ? flt_mem[(rd_n[1] - 1) & 511] : {$urandom, $urandom};
        ipsum_rd_data  = last_rd[2] ? ps_mem[(rd_n[2] - 1) & 511]  : {$urandom, $urandom};
        filter_fifo_full = (cyc >= full_lo) && (cyc < full_hi);
        pe_busy = (cyc < busy_until);
        if (produced < n_ps_e && $urandom_range(99) < produce_pct) begin
            opq.push_back({$urandom, $urandom});
            produced++;
        end
        opsum_fifo_empty = (opq.size() == 0);
        opsum            = (opq.size() > 0) ? opq[0] : {$urandom, $urandom};
        if (cyc == restart_at) begin
            start = 1'b1;
            {S, F, U, n, p, q} = {6'd2, 6'd2, 3'd1, 3'd1, 5'd4, 3'd1};
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic tick();
        sample();
        drive();
    endtask

    // Called just after a rising edge: presents start with the given config.
    task automatic begin_pass(input int s, input int f, input int u, input int nn,
                              input int pp, input int qq, input int flo, input int fhi,
                              input int bu, input int pct, input int rs);
        int w;
        w          = (f - 1) * u + s;
        n_exp[0]   = nn * w * qq;
        n_exp[1]   = (pp * qq * s) / 4;
        n_exp[2]   = (pp * nn * f) / 4;
        n_ps_e     = n_exp[2];
        for (int k = 0; k < 3; k++) begin
            rd_n[k] = 0; push_n[k] = 0; last_rd[k] = 0; first_rd[k] = -1; first_push[k] = -1;
        end
        wr_n = 0; last_wr_cyc = -1; done_n = 0; done_cyc = -1; cfg_n = 0; busy_first = -1;
        last_pop = 0; prev_pe_busy = 0; opq.delete(); produced = 0;
        full_lo = flo; full_hi = fhi; busy_until = bu; produce_pct = pct; restart_at = rs;
        c_s = 6'(s); c_f = 6'(f); c_u = 3'(u); c_n = 3'(nn); c_p = 5'(pp); c_q = 3'(qq);
        {S, F, U, n, p, q} = {c_s, c_f, c_u, c_n, c_p, c_q};
        start = 1'b1;
        pe_busy = (bu > 0);
        filter_fifo_full = 1'b0;
        opsum_fifo_empty = 1'b1;
        cyc = 0;
    endtask

    task automatic run_pass(input int s, input int f, input int u, input int nn,
                            input int pp, input int qq, input int flo, input int fhi,
                            input int bu, input int pct, input int rs);
        begin_pass(s, f, u, nn, pp, qq, flo, fhi, bu, pct, rs);
        while (done_n == 0 && cyc < 5000) tick();
        if (done_n == 0) check_val("done_timeout", done_n, 1);
        repeat (4) tick();
        check_val("ifmap_reads",   rd_n[0],   n_exp[0]);
        check_val("filter_reads",  rd_n[1],   n_exp[1]);
        check_val("ipsum_reads",   rd_n[2],   n_exp[2]);
        check_val("ifmap_pushes",  push_n[0], n_exp[0]);
        check_val("filter_pushes", push_n[1], n_exp[1]);
        check_val("ipsum_pushes",  push_n[2], n_exp[2]);
        check_val("opsum_writes",  wr_n,      n_ps_e);
        check_val("done_count",    done_n,    1);
        check_val("cfg_count",     cfg_n,     1);
        check_val("busy_latency",  busy_first, 1);
        check_val("busy_after",    busy, 0);
        check_val("done_wait_pe",  done_cyc > busy_until, 1);
        for (int k = 0; k < 3; k++) begin
            if (n_exp[k] > 0) begin
                check_val("first_rd_cycle",   first_rd[k],   2);
                check_val("first_push_cycle", first_push[k], 3);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            if_mem[i]  = 16'($urandom);
            flt_mem[i] = {$urandom, $urandom};
            ps_mem[i]  = {$urandom, $urandom};
        end
        reset = 1'b0; start = 1'b0;
        {S, F, U, n, p, q} = 26'd0;
        pe_busy = 1'b0;
        ifmap_fifo_full = 1'b0; filter_fifo_full = 1'b0; ipsum_fifo_full = 1'b0;
        opsum_fifo_empty = 1'b1; opsum = 64'd0;
        ifmap_rd_data = 16'd0; filter_rd_data = 64'd0; ipsum_rd_data = 64'd0;
        n_ps_e = 0; n_exp = '{0, 0, 0}; restart_at = -1; full_lo = 0; full_hi = 0;
        busy_until = 0; produce_pct = 0; produced = 0;
        @(negedge clk);
        check_val("reset_outputs", any_out(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("idle_outputs", any_out(), 0);
        @(posedge clk); #1;

        // large layer, PE never full, opsum always available
        run_pass(11, 55, 4, 1, 16, 1, -1, -1, 0, 100, -1);
        // small layer, PE held busy past stream completion
        run_pass(3, 4, 1, 1, 4, 1, -1, -1, 60, 50, -1);
        // filter FIFO full for 10 cycles, opsum empty toggling
        run_pass(11, 55, 4, 1, 16, 1, 50, 60, 0, 40, -1);
        // start pulsed mid-stream with a different config
        run_pass(3, 4, 1, 1, 4, 1, -1, -1, 0, 60, 20);

        // reset during STREAM, then a fresh pass
        begin_pass(3, 4, 1, 1, 4, 1, -1, -1, 0, 100, -1);
        repeat (6) tick();
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_mid_outputs", any_out(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_hold_outputs", any_out(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_val("rst_no_done", {done, busy}, 0);
        @(posedge clk); #1;
        run_pass(3, 4, 1, 1, 4, 1, -1, -1, 0, 70, -1);

        // randomized layers
        for (int k = 0; k < 3; k++) begin
            int flo;
            flo = $urandom_range(10, 40);
            run_pass($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 4),
                     $urandom_range(1, 3), 4 * $urandom_range(1, 7), $urandom_range(1, 3),
                     flo, flo + $urandom_range(1, 10), $urandom_range(0, 30),
                     $urandom_range(30, 100), -1);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/pe_stream_ctrl.md
# pe_stream_ctrl

On-chip controller that configures one PE wrapper and streams its operands. It loads a layer configuration, pulses the PE configure port, then fetches ifmap, filter and ipsum words from three synchronous-read buffers and pushes them into the PE input FIFOs under full back-pressure. In parallel it pops opsum words into an output buffer and raises `done` when the layer pass completes. It sits between the global buffer and `PE_wrapper` and replaces bench-driven stimulus.

## Interface
- DATA_WIDTH_IFMAP, 16, ifmap word width
- DATA_WIDTH_FILTER, 64, filter word width (4 packed weights)
- DATA_WIDTH_PSUM, 64, psum word width (4 packed psums)
- S_WIDTH 6, F_WIDTH 6, U_WIDTH 3, n_WIDTH 3, p_WIDTH 5, q_WIDTH 3, config field widths
- ADDR_WIDTH, 16, buffer address width; CNT_WIDTH, 16, word-counter width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle request to run a layer pass; sampled only in IDLE
- S, F, U, n, p, q  in  field widths  layer config, sampled with `start`
- busy  out  1  high from the cycle after accepted `start` until DONE exits
- done  out  1  one-cycle pulse at completion
- pe_enable  out  1  equals busy
- pe_configure  out  1  one-cycle configure pulse
- pe_S..pe_q  out  field widths  config, valid only while pe_configure=1, else 0
- pe_busy  in  1  PE busy
- push_ifmap/ifmap/ifmap_fifo_full, push_filter/filter/filter_fifo_full, push_ipsum/ipsum/ipsum_fifo_full  PE input streams
- pop_opsum  out  1; opsum  in  DATA_WIDTH_PSUM; opsum_fifo_empty  in  1
- {ifmap,filter,ipsum}_rd_en  out  1; _rd_addr  out  ADDR_WIDTH; _rd_data  in  stream width; 1-cycle read latency
- opsum_wr_en  out  1; opsum_wr_addr  out  ADDR_WIDTH; opsum_wr_data  out  DATA_WIDTH_PSUM

## Operation
- FSM: IDLE → CFG → STREAM → DONE → IDLE.
- IDLE: latch config on `start`. Compute W=(F−1)·U+S, N_if=n·W·q, N_flt=(p·q·S)>>2 and N_ps=(p·n·F)>>2. All values are in CNT_WIDTH; the config must keep them in range. p·q·S and p·n·F must be multiples of 4.
- CFG, one cycle: pe_configure=1 and pe_S..pe_q driven.
- STREAM: run three readers and one opsum drainer concurrently.
  - Reader: with no read outstanding, count<N, and fifo_full=0, assert rd_en with rd_addr=count. Next cycle, push=1, data=rd_data, count+1. At most one read outstanding per reader.
  - The block is the only pusher, so a fetched word always fits.
  - Drainer: pop_opsum = !opsum_fifo_empty && opsum_cnt<N_ps && !gap. The gap bit is set for the one cycle after each pop.
  - opsum_wr_en=pop_opsum, opsum_wr_data=opsum, opsum_wr_addr=opsum_cnt, all in the same cycle.
- STREAM → DONE when all four counts reach their totals and pe_busy=0. A stream with total 0 is complete immediately.
- DONE: done=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: every output 0 and every counter 0, state IDLE.
- start at cycle t → busy and pe_configure at t+1 → first rd_en at t+2 → first push at t+3.
- Peak rate is 1 word per 2 cycles per stream, and 1 pop per 2 cycles.
- fifo_full high: no new rd_en. A read already issued still pushes next cycle.
- Assertion of reset mid-pass: immediate return to IDLE with outputs 0. No done pulse. Counters clear.
- done occurs at least 1 cycle after the final opsum write.

## Structure
- Shared package `pe_ctrl_pkg`: state enum and word-count function (W, N_if, N_flt, N_ps).
- Sub-module `pe_stream_reader`, parameterized by data width, instantiated 3×. It contains the counter, outstanding flag and rd/push sequencing, with `go`, `total` and `complete` ports.
- Top level holds the FSM, config registers and opsum drainer.

## Test plan
- S=11, F=55, U=4, n=1, p=16, q=1, PE model never full → 227 ifmap reads (addr 0..226), 44 filter, 220 ipsum. 220 opsum writes in order to addr 0..219. Exactly one done.
- S=3, F=4, U=1, n=1, p=4, q=1 → W=6. ifmap 6, filter 3, ipsum 4, opsum 4. pe_configure is one cycle, with pe_S=3 and pe_F=4.
- filter_fifo_full held high 10 cycles mid-stream → no filter_rd_en in that window, at most one trailing push. Other streams unaffected. Final filter count is 44.
- opsum_fifo_empty toggling → pops only when non-empty, never in back-to-back cycles. wr_data equals opsum in the pop cycle.
- reset low during STREAM → all outputs 0 same cycle, no done. A fresh start then completes normally.
- start pulsed during STREAM → ignored, config unchanged, single done.
